clock_div_error_monitor: RTL and testbench



---
 rtl/clock_div_error_monitor.sv | 175 +++++++++++++++++
 tb/tb_clock_div_error_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_error_monitor.sv
// -----------------------------------------------------------------------------
// clock_div_error_monitor
//
// Consumer end of the divisor/error-flag loop. Turns the divisor from the
// adaptive clock search into a launch strobe and divided clock for the path
// under test. It then checks whether each launch completes (i_Capture_Done)
// within one divided period, and returns o_Error_Flag to the search logic.
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   i_Enable        monitor run enable
//   i_Clk_Div       requested divisor; period P = max(i_Clk_Div, MIN_PERIOD)
//   i_Capture_Done  path-under-test completion pulse/level
//   o_Launch        one-cycle strobe in the first cycle of each window
//   o_Div_Clk       divided clock, high for the first ceil(P/2) window cycles
//   o_Error_Flag    last evaluated window missed its deadline
//   o_Latency       launch-to-done cycles of the last hit window
//   o_Window_Valid  one-cycle pulse when a window result is registered
//
// Optional build macro:
//   ERR_HYST_EN  When defined, a miss sets o_Error_Flag immediately. The flag
//                clears only after CLEAR_HITS consecutive hit windows.
// -----------------------------------------------------------------------------
module clock_div_error_monitor #(
   parameter int DATA_WIDTH = 8,
   parameter int MIN_PERIOD = 1,
   parameter int CLEAR_HITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_Enable,
   input  logic [DATA_WIDTH-1:0] i_Clk_Div,
   input  logic                  i_Capture_Done,
   output logic                  o_Launch,
   output logic                  o_Div_Clk,
   output logic                  o_Error_Flag,
   output logic [DATA_WIDTH-1:0] o_Latency,
   output logic                  o_Window_Valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,   // window open, no done seen yet
      HOLD = 2'd2    // done credited, waiting out the rest of the window
   } state_t;

   // The floor never drops below 1, so that P-1 cannot underflow.
   localparam int                  MIN_P_INT = (MIN_PERIOD < 1) ? 1 : MIN_PERIOD;
   localparam logic [DATA_WIDTH-1:0] MIN_P   = DATA_WIDTH'(MIN_P_INT);
   localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH:0]   ONE_W   = (DATA_WIDTH+1)'(1);

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   period_q, period_d;
   logic [DATA_WIDTH-1:0]   p_req;
   logic [DATA_WIDTH-1:0]   lat_d;
   logic [DATA_WIDTH:0]     half_d;
   logic                    launch_d, div_clk_d, err_d, valid_d;
   logic                    start, hit_now, win_end, miss;

`ifdef ERR_HYST_EN
   // The extra bit keeps the width non-zero and lets the counter hold CLEAR_HITS.
   localparam int HW = $clog2(CLEAR_HITS + 2);
   logic [HW-1:0] hit_cnt_q, hit_cnt_d;
`endif

   // A divisor of 0, or any value below the floor, becomes the floor.
   assign p_req = (i_Clk_Div < MIN_P) ? MIN_P : i_Clk_Div;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      lat_d    = o_Latency;
      err_d    = o_Error_Flag;
      launch_d = 1'b0;
      valid_d  = 1'b0;
      start    = 1'b0;
      hit_now  = 1'b0;
      win_end  = 1'b0;
      miss     = 1'b0;
`ifdef ERR_HYST_EN
      hit_cnt_d = hit_cnt_q;
`endif

      unique case (state_q)
         IDLE: start = i_Enable;

         WAIT, HOLD: begin
            // Only the first done of a window counts. HOLD ignores later ones.
            hit_now = (state_q == WAIT) && i_Capture_Done;
            win_end = (cnt_q == period_q - ONE);

            if (hit_now) begin
               lat_d   = cnt_q;
               state_d = HOLD;
            end

            if (win_end) begin
               valid_d = 1'b1;
               // A done in the final cycle still counts as a hit.
               miss    = (state_q == WAIT) && !i_Capture_Done;
`ifdef ERR_HYST_EN
               if (miss) begin
                  err_d     = 1'b1;
                  hit_cnt_d = '0;
               end else begin
                  if (hit_cnt_q < HW'(CLEAR_HITS))
                     hit_cnt_d = hit_cnt_q + HW'(1);
                  if (hit_cnt_d >= HW'(CLEAR_HITS))
                     err_d = 1'b0;
               end
`else
               err_d = miss;
`endif
               if (i_Enable) start   = 1'b1;
               else          state_d = IDLE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end

         default: state_d = IDLE;
      endcase

      // A new window opens from IDLE or back-to-back at a window end. The
      // divisor is sampled only here, so mid-window changes wait for it.
      if (start) begin
         period_d = p_req;
         cnt_d    = '0;
         launch_d = 1'b1;
         state_d  = WAIT;
      end

      // The divided clock is registered from next-state values, so it lines
      // up with the counter cycle it describes.
      half_d    = ({1'b0, period_d} + ONE_W) >> 1;
      div_clk_d = (state_d != IDLE) && ({1'b0, cnt_d} < half_d);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         period_q       <= ONE;
         o_Launch       <= 1'b0;
         o_Div_Clk      <= 1'b0;
         o_Error_Flag   <= 1'b0;
         o_Latency      <= '0;
         o_Window_Valid <= 1'b0;
`ifdef ERR_HYST_EN
         hit_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         o_Launch       <= launch_d;
         o_Div_Clk      <= div_clk_d;
         o_Error_Flag   <= err_d;
         o_Latency      <= lat_d;
         o_Window_Valid <= valid_d;
`ifdef ERR_HYST_EN
         hit_cnt_q      <= hit_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_clock_div_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_clock_div_error_monitor
//
// Directed bench for clock_div_error_monitor. A window-level reference model
// predicts every output on every cycle. Hand-computed literal checks pin the
// model at each scenario: steady hits, steady misses, mid-window divisor
// change, divisor 0, enable drop, reset mid-window, and flag hysteresis.
// -----------------------------------------------------------------------------
module tb_clock_div_error_monitor;

   localparam int DW   = 8;
   localparam int MINP = 1;
   localparam int CH   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [DW-1:0] div;
   logic          done = 1'b0;
   logic          o_Launch, o_Div_Clk, o_Error_Flag, o_Window_Valid;
   logic [DW-1:0] o_Latency;

   clock_div_error_monitor #(
      .DATA_WIDTH(DW), .MIN_PERIOD(MINP), .CLEAR_HITS(CH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_Enable       (en),
      .i_Clk_Div      (div),
      .i_Capture_Done (done),
      .o_Launch       (o_Launch),
      .o_Div_Clk      (o_Div_Clk),
      .o_Error_Flag   (o_Error_Flag),
      .o_Latency      (o_Latency),
      .o_Window_Valid (o_Window_Valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- done generator ----------------
   // done goes high when the number of cycles since the last observed launch
   // equals this window's delay. Delays come from a queue, falling back to
   // base_delay. done_hi holds done high continuously.
   int base_delay = 99;
   int cur_delay  = 99;
   int since      = 1000;
   bit done_hi    = 1'b0;
   int dq[$];

   initial begin
      forever begin
         @(negedge clk);
         if (o_Launch === 1'b1) begin
            since     = 0;
            cur_delay = (dq.size() > 0) ? dq.pop_front() : base_delay;
         end else begin
            since++;
         end
         done = done_hi || (since == cur_delay);
      end
   end

   // ---------------- reference model ----------------
   // Inputs as seen by the DUT at each rising edge.
   logic          s_rst, s_en, s_done;
   logic [DW-1:0] s_div;
   always @(posedge clk) begin
      s_rst  <= rst;
      s_en   <= en;
      s_div  <= div;
      s_done <= done;
   end

   // Window view: open or not, position within it, its period, and the
   // position of the first done (-1 until one arrives).
   bit            m_open = 1'b0;
   int            m_pos = 0, m_p = 1, m_hit = -1, m_hits = 0;
   bit            m_start;
   logic          e_launch, e_div, e_err, e_valid;
   logic [DW-1:0] e_lat;
   bit            cmp_en = 1'b0;

   task automatic score_window(input bit was_miss);
`ifdef ERR_HYST_EN
      if (was_miss) begin
         e_err  = 1'b1;
         m_hits = 0;
      end else begin
         if (m_hits < CH) m_hits++;
         if (m_hits >= CH) e_err = 1'b0;
      end
`else
      e_err = was_miss;
`endif
   endtask

   task automatic model_step();
      if (s_rst) begin
         m_open = 0; m_pos = 0; m_p = 1; m_hit = -1; m_hits = 0;
         e_launch = 0; e_div = 0; e_err = 0; e_valid = 0; e_lat = '0;
      end else begin
         m_start  = 0;
         e_launch = 0;
         e_valid  = 0;
         if (!m_open) begin
            m_start = s_en;
         end else begin
            if (m_hit < 0 && s_done) begin
               m_hit = m_pos;
               e_lat = DW'(m_pos);
            end
            if (m_pos == m_p - 1) begin
               e_valid = 1;
               score_window(m_hit < 0);
               if (s_en) m_start = 1;
               else      m_open  = 0;
            end else begin
               m_pos++;
            end
         end
         if (m_start) begin
            m_open   = 1;
            m_p      = (int'(s_div) > MINP) ? int'(s_div) : MINP;
            m_pos    = 0;
            m_hit    = -1;
            e_launch = 1;
         end
         e_div = m_open && (m_pos < (m_p + 1) / 2);
      end
   endtask

   // Compare process: model advances once per cycle, outputs checked mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         model_step();
         if (cmp_en) begin
            check("launch",  o_Launch,       e_launch);
            check("div_clk", o_Div_Clk,      e_div);
            check("err",     o_Error_Flag,   e_err);
            check("latency", o_Latency,      e_lat);
            check("valid",   o_Window_Valid, e_valid);
         end
      end
   end

   // ---------------- bounded wait helpers ----------------
   task automatic wait_launch();
      int n = 0;
      do begin
         run(1);
         n++;
      end while (o_Launch !== 1'b1 && n < 100);
      if (o_Launch !== 1'b1) check("launch_timeout", o_Launch, 1);
   endtask

   task automatic wait_valid(output logic f);
      int n = 0;
      do begin
         run(1);
         n++;
      end while (o_Window_Valid !== 1'b1 && n < 100);
      if (o_Window_Valid !== 1'b1) check("valid_timeout", o_Window_Valid, 1);
      f = o_Error_Flag;
   endtask

   // Window length in cycles, and the number of its cycles with o_Div_Clk high.
   task automatic measure_window(output int gap, output int high);
      wait_launch();
      gap  = 0;
      high = 0;
      do begin
         high += int'(o_Div_Clk);
         gap++;
         run(1);
      end while (o_Launch !== 1'b1 && gap < 300);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int   gap, high, n, vcnt, lcnt;
      logic f1, f2, f3;

      rst = 1'b1; en = 1'b0; div = 8'd4;
      run(2);
      cmp_en = 1'b1;
      check("rst_launch",  o_Launch,       0);
      check("rst_div_clk", o_Div_Clk,      0);
      check("rst_err",     o_Error_Flag,   0);
      check("rst_latency", o_Latency,      0);
      check("rst_valid",   o_Window_Valid, 0);
      rst = 1'b0;
      run(2);
      check("idle_no_launch", o_Launch, 0);

      // 1: P=4, done 2 cycles after launch.
      base_delay = 2; div = 8'd4; en = 1'b1;
      run(20);
      check("t1_latency", o_Latency,    2);
      check("t1_err",     o_Error_Flag, 0);
      measure_window(gap, high);
      check("t1_gap",  gap,  4);
      check("t1_high", high, 2);

      // 2: P=3, done 5 cycles after launch, so every window misses.
      div = 8'd3; base_delay = 5;
      run(20);
      check("t2_err",     o_Error_Flag, 1);
      check("t2_latency", o_Latency,    2);
      wait_valid(f1);
      check("t2_valid_with_launch", o_Launch, 1);
      measure_window(gap, high);
      check("t2_gap",  gap,  3);
      check("t2_high", high, 2);

      // 3: divisor 4 -> 8 in the 2nd cycle of a window.
      div = 8'd4; base_delay = 2;
      run(20);
      wait_launch();
      n = 0;
      do begin
         run(1);
         n++;
         if (n == 1) div = 8'd8;
      end while (o_Launch !== 1'b1 && n < 40);
      check("t3_old_gap", n, 4);
      measure_window(gap, high);
      check("t3_new_gap",  gap,  8);
      check("t3_new_high", high, 4);
      check("t3_err",      o_Error_Flag, 0);

      // 4: divisor 0 -> P=1. Done held high, then held low.
      div = 8'd0; done_hi = 1'b1;
      run(20);
      measure_window(gap, high);
      check("t4_gap",     gap,  1);
      check("t4_high",    high, 1);
      check("t4_latency", o_Latency,    0);
      check("t4_err_hit", o_Error_Flag, 0);
      done_hi = 1'b0;
      run(10);
      check("t4_err_miss",   o_Error_Flag,   1);
      check("t4_lat_held",   o_Latency,      0);
      check("t4_valid_each", o_Window_Valid, 1);
      check("t4_launch_each", o_Launch,      1);

      // Enable dropped mid-window: window finishes, one result, then idle.
      div = 8'd6; base_delay = 3;
      run(20);
      check("drop_lat_before", o_Latency, 3);
      wait_launch();
      run(2);
      en = 1'b0;
      vcnt = 0; lcnt = 0;
      for (int i = 0; i < 10; i++) begin
         run(1);
         vcnt += int'(o_Window_Valid);
         lcnt += int'(o_Launch);
      end
      check("drop_valid_count",  vcnt, 1);
      check("drop_launch_count", lcnt, 0);
      check("drop_div_clk_idle", o_Div_Clk,    0);
      check("drop_err",          o_Error_Flag, 0);

      // 5: reset in the middle of a WAIT window.
      en = 1'b1; div = 8'd8; base_delay = 6;
      wait_launch();
      run(2);
      rst = 1'b1;
      run(1);
      check("t5_launch",  o_Launch,       0);
      check("t5_div_clk", o_Div_Clk,      0);
      check("t5_err",     o_Error_Flag,   0);
      check("t5_latency", o_Latency,      0);
      check("t5_valid",   o_Window_Valid, 0);
      rst = 1'b0;
      run(1);
      check("t5_restart_launch", o_Launch, 1);
      run(30);
      check("t5_latency_after", o_Latency, 6);

      // 6: window sequence miss, hit, hit.
      rst = 1'b1; en = 1'b0;
      run(1);
      rst = 1'b0;
      dq.push_back(99); dq.push_back(1); dq.push_back(1);
      base_delay = 1; div = 8'd4; en = 1'b1;
      wait_valid(f1);
      wait_valid(f2);
      wait_valid(f3);
`ifdef ERR_HYST_EN
      check("t6_flag_miss", f1, 1);
      check("t6_flag_hit1", f2, 1);
      check("t6_flag_hit2", f3, 0);
`else
      check("t6_flag_miss", f1, 1);
      check("t6_flag_hit1", f2, 0);
      check("t6_flag_hit2", f3, 0);
`endif
      en = 1'b0;
      run(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
